// File: rtl/pll_lock_monitor_pkg.sv
// Shared definitions for the PLL lock monitor: state encoding and parameter helpers.
// Status/CSR blocks import this package to decode state_o.
package pll_lock_monitor_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILISE = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_mon_sync.sv
// N-stage single-bit synchronizer with asynchronous active-high reset to 0.
module pll_mon_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Sequences the board PLL reset, waits for stable lock and then releases the system reset.
// Retries the PLL on lock timeout and re-sequences on loss of lock in RUN.
module pll_lock_monitor
  import pll_lock_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             locked_i,
  input  logic             soft_rst_i,
  output logic             pll_rst_o,
  output logic             rst_o,
  output logic             ready_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] retry_cnt_o,
  output logic [CNT_W-1:0] loss_cnt_o
);

  localparam int unsigned TMAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] PRST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STAB_LAST = TW'(STABLE_CYCLES - 1);

  logic             lock_s;
  pll_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] retry_q, loss_q;
  logic             retry_inc, loss_inc;
  logic             pll_rst_q, rst_q, ready_q;

  pll_mon_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (locked_i),
    .q_o   (lock_s)
  );

  // Lock arrival beats timeout in WAIT_LOCK; lock drop beats completion in STABILISE.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (soft_rst_i) begin
      state_d = PLL_RESET;
    end else begin
      case (state_q)
        PLL_RESET: if (timer_q == PRST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABILISE;
          end else if (timer_q == TOUT_LAST) begin
            state_d   = PLL_RESET;
            retry_inc = 1'b1;
          end
        end
        STABILISE: begin
          if (!lock_s) state_d = WAIT_LOCK;
          else if (timer_q == STAB_LAST) state_d = RUN;
        end
        RUN: begin
          if (!lock_s) begin
            state_d  = PLL_RESET;
            loss_inc = 1'b1;
          end
        end
        default: state_d = PLL_RESET;
      endcase
    end
  end

  // A soft restart re-arms the PLL reset timer even when already in PLL_RESET.
  always_comb begin
    timer_d = timer_q;
    if (soft_rst_i || (state_d != state_q)) timer_d = '0;
    else if (state_q != RUN) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= PLL_RESET;
      timer_q   <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      rst_q     <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      if (retry_inc && (retry_q != '1)) retry_q <= retry_q + 1'b1;
      if (loss_inc && (loss_q != '1)) loss_q <= loss_q + 1'b1;
      pll_rst_q <= (state_d == PLL_RESET);
      rst_q     <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign rst_o       = rst_q;
  assign ready_o     = ready_q;
  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;
  assign loss_cnt_o  = loss_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor with short timing parameters and 2-bit counters.
module tb_pll_lock_monitor;

  localparam int CNT_W = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             locked_i;
  logic             soft_rst_i;
  logic             pll_rst_o;
  logic             rst_o;
  logic             ready_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] retry_cnt_o;
  logic [CNT_W-1:0] loss_cnt_o;

  int tests = 0;
  int fails = 0;

  pll_lock_monitor #(
    .SYNC_STAGES    (2),
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .STABLE_CYCLES  (8),
    .CNT_W          (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .locked_i    (locked_i),
    .soft_rst_i  (soft_rst_i),
    .pll_rst_o   (pll_rst_o),
    .rst_o       (rst_o),
    .ready_o     (ready_o),
    .state_o     (state_o),
    .retry_cnt_o (retry_cnt_o),
    .loss_cnt_o  (loss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st, input logic prst,
                          input logic srst, input logic rdy);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".pll_rst"}, 32'(pll_rst_o), 32'(prst));
    chk({tag, ".rst"}, 32'(rst_o), 32'(srst));
    chk({tag, ".ready"}, 32'(ready_o), 32'(rdy));
  endtask

  initial begin
    rst_i      = 1'b1;
    locked_i   = 1'b0;
    soft_rst_i = 1'b0;
    tick(2);
    chk_outs("reset", 2'd0, 1'b1, 1'b1, 1'b0);
    chk("reset.retry", 32'(retry_cnt_o), 32'd0);
    chk("reset.loss", 32'(loss_cnt_o), 32'd0);

    // Nominal lock: pll_rst held for exactly 4 edges after release.
    rst_i = 1'b0;
    tick(3);
    chk_outs("nom.prst_hold", 2'd0, 1'b1, 1'b1, 1'b0);
    tick(1);
    chk_outs("nom.wait", 2'd1, 1'b0, 1'b1, 1'b0);
    tick(9);
    locked_i = 1'b1;
    tick(2);
    chk("nom.sync_lat", 32'(state_o), 32'd1);
    tick(1);
    chk_outs("nom.stab", 2'd2, 1'b0, 1'b1, 1'b0);
    tick(7);
    chk_outs("nom.stab_end", 2'd2, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_outs("nom.run", 2'd3, 1'b0, 1'b0, 1'b1);
    chk("nom.retry", 32'(retry_cnt_o), 32'd0);
    chk("nom.loss", 32'(loss_cnt_o), 32'd0);

    // Loss of lock in RUN, then relock.
    locked_i = 1'b0;
    tick(2);
    chk_outs("loss.pre", 2'd3, 1'b0, 1'b0, 1'b1);
    tick(1);
    chk_outs("loss.reset", 2'd0, 1'b1, 1'b1, 1'b0);
    chk("loss.cnt", 32'(loss_cnt_o), 32'd1);
    locked_i = 1'b1;
    tick(4);
    chk("loss.wait", 32'(state_o), 32'd1);
    tick(1);
    chk("loss.stab", 32'(state_o), 32'd2);
    tick(8);
    chk_outs("loss.rerun", 2'd3, 1'b0, 1'b0, 1'b1);
    chk("loss.cnt_keep", 32'(loss_cnt_o), 32'd1);

    // Soft restart in RUN.
    soft_rst_i = 1'b1;
    tick(1);
    soft_rst_i = 1'b0;
    chk_outs("soft.reset", 2'd0, 1'b1, 1'b1, 1'b0);
    chk("soft.loss", 32'(loss_cnt_o), 32'd1);
    tick(4);
    chk("soft.wait", 32'(state_o), 32'd1);
    tick(1);
    chk("soft.stab", 32'(state_o), 32'd2);
    tick(2);

    // Async reset mid-STABILISE takes effect before the next edge.
    rst_i = 1'b1;
    #1;
    chk_outs("async", 2'd0, 1'b1, 1'b1, 1'b0);
    chk("async.loss", 32'(loss_cnt_o), 32'd0);
    tick(1);
    rst_i = 1'b0;

    // Glitch in STABILISE: lock still high, sync chain restarts from 0.
    tick(5);
    chk("glitch.stab", 32'(state_o), 32'd2);
    tick(4);
    locked_i = 1'b0;
    tick(2);
    chk("glitch.still_stab", 32'(state_o), 32'd2);
    tick(1);
    chk_outs("glitch.back", 2'd1, 1'b0, 1'b1, 1'b0);
    chk("glitch.retry", 32'(retry_cnt_o), 32'd0);

    // No lock: WAIT_LOCK lasts 32 edges from a cleared timer, PLL reset pulses 4 high.
    for (int k = 1; k <= 4; k++) begin
      tick(31);
      chk_outs($sformatf("nolock%0d.wait", k), 2'd1, 1'b0, 1'b1, 1'b0);
      chk($sformatf("nolock%0d.retry_pre", k), 32'(retry_cnt_o), 32'((k - 1 > 3) ? 3 : k - 1));
      tick(1);
      chk_outs($sformatf("nolock%0d.prst", k), 2'd0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("nolock%0d.retry", k), 32'(retry_cnt_o), 32'((k > 3) ? 3 : k));
      tick(3);
      chk($sformatf("nolock%0d.prst_hold", k), 32'(pll_rst_o), 32'd1);
      tick(1);
      chk($sformatf("nolock%0d.prst_fall", k), 32'(pll_rst_o), 32'd0);
    end

    // Clean lock after the glitch/timeouts completes.
    locked_i = 1'b1;
    tick(3);
    chk("relock.stab", 32'(state_o), 32'd2);
    tick(8);
    chk_outs("relock.run", 2'd3, 1'b0, 1'b0, 1'b1);
    chk("relock.retry", 32'(retry_cnt_o), 32'd3);

    // Lock and timeout on the same edge: lock wins.
    rst_i = 1'b1;
    locked_i = 1'b0;
    tick(1);
    chk("sim.retry_clr", 32'(retry_cnt_o), 32'd0);
    rst_i = 1'b0;
    tick(4);
    chk("sim.wait", 32'(state_o), 32'd1);
    tick(29);
    locked_i = 1'b1;
    tick(2);
    chk("sim.pre", 32'(state_o), 32'd1);
    tick(1);
    chk("sim.state", 32'(state_o), 32'd2);
    chk("sim.retry", 32'(retry_cnt_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
